// File: rtl/decoded_instr_queue_pkg.sv
// Types shared by the decoded-instruction queue and its neighbours.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package decoded_instr_queue_pkg;

    // Decoded instruction as handed from decode to issue.
    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } scoreboard_entry_t;

    // One queue slot: the instruction plus its control-flow marker.
    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } dq_entry_t;

    // Branch-shadow state: RUN issues freely, WAIT_BRANCH holds the head.
    typedef enum logic {
        DQ_RUN,
        DQ_WAIT_BRANCH
    } dq_state_e;

    // True for powers of two that are at least 2.
    function automatic logic is_pow2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/decoded_instr_queue.sv
// Decoded-instruction queue between decode and issue, with single-branch speculation.
// Latency: 1 cycle decode->issue minimum (no bypass); head stable until popped.
// Backpressure: ack drops when full (from registered count only); head withheld while a branch is outstanding.
module decoded_instr_queue
    import decoded_instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  scoreboard_entry_t          decoded_instr_i,
    input  logic                       decoded_instr_valid_i,
    input  logic                       is_ctrl_flow_i,
    output logic                       decoded_instr_ack_o,
    output scoreboard_entry_t          decoded_instr_o,
    output logic                       decoded_instr_valid_o,
    output logic                       is_ctrl_flow_o,
    input  logic                       issue_ack_i,
    input  logic                       resolve_branch_i,
    output logic [$clog2(DEPTH):0]     usage_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("decoded_instr_queue: DEPTH must be a power of two and >= 2");
    end

    dq_entry_t           mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    dq_state_e           state_q;
    dq_state_e           state_d;
    dq_entry_t           head;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];

    // Ack is a function of registered occupancy only, so a pop in a full
    // cycle frees the slot for the next cycle rather than this one.
    assign decoded_instr_ack_o   = ~full & ~flush_i;
    assign push                  = decoded_instr_ack_o & decoded_instr_valid_i;

    assign decoded_instr_valid_o = ~empty & (state_q == DQ_RUN) & ~flush_i;
    assign pop                   = decoded_instr_valid_o & issue_ack_i;

    assign decoded_instr_o       = head.sbe;
    assign is_ctrl_flow_o        = head.is_ctrl_flow;
    assign usage_o               = count_q;

    // Slot write on push; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= '{sbe: decoded_instr_i, is_ctrl_flow: is_ctrl_flow_i};
        end
    end

    // Next occupancy: flush empties, push and pop together leave it unchanged.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Branch shadow: popping a control-flow entry blocks issue until resolve.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = DQ_RUN;
        end else begin
            case (state_q)
                DQ_RUN: begin
                    if (pop && head.is_ctrl_flow && !resolve_branch_i) begin
                        state_d = DQ_WAIT_BRANCH;
                    end
                end
                DQ_WAIT_BRANCH: begin
                    if (resolve_branch_i) begin
                        state_d = DQ_RUN;
                    end
                end
                default: state_d = DQ_RUN;
            endcase
        end
    end

    // Pointers, occupancy and branch-shadow state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= DQ_RUN;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && full));

    a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop && empty));

endmodule
